// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: source count, register window
// offsets and STATUS field layout, common to RTL, bridge and software header.
package irq_ctrl_pkg;

    localparam int NIRQ = 6;
    localparam int ID_W = 3;

    typedef logic [NIRQ-1:0] irq_vec_t;

    localparam logic [1:0] IRQ_MASK = 2'd0;
    localparam logic [1:0] IRQ_MODE = 2'd1;
    localparam logic [1:0] IRQ_PEND = 2'd2;
    localparam logic [1:0] IRQ_STAT = 2'd3;

    localparam int STAT_VALID_BIT = 31;
    localparam int STAT_ISR_LSB   = 8;
    localparam int STAT_ID_LSB    = 0;

    localparam logic [ID_W-1:0] ID_NONE = 3'h7;

    function automatic logic [31:0] pack_status(input logic valid,
                                                input irq_vec_t isr,
                                                input logic [ID_W-1:0] id);
        logic [31:0] s;
        s = '0;
        s[STAT_VALID_BIT]            = valid;
        s[STAT_ISR_LSB +: NIRQ]      = isr;
        s[STAT_ID_LSB +: ID_W]       = valid ? id : ID_NONE;
        return s;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; bit 0 is the highest priority.
// Reports ID_NONE with valid low when no bit is set.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = NIRQ
) (
    input  logic [N-1:0]    vec,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        valid = 1'b0;
        id    = ID_NONE;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller feeding CP0 HWInt[7:2], with per-source
// mask, edge/level mode, pending and in-service tracking behind a 4-word window.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [NIRQ-1:0] RST_MASK = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_src,
    input  logic            sel,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic            re,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic [NIRQ-1:0] hwint,
    output logic            irq_any
);

    irq_vec_t mask, mode, pend, isr, prev_src;
    irq_vec_t below_isr, eligible, ack_vec, eoi_vec, w1c, pend_next;

    logic            cand_valid, isr_valid;
    logic [ID_W-1:0] cand_id, isr_id;
    logic            wr_stb, ack, eoi;
    logic            unused_din;

    assign unused_din = ^din[31:NIRQ];

    // A write strobe always wins over a read strobe, so ack never coincides with EOI.
    assign wr_stb = sel & we;
    assign ack    = sel & re & ~we & (addr == IRQ_STAT) & cand_valid;
    assign eoi    = wr_stb & (addr == IRQ_STAT) & isr_valid;

    irq_prio_enc #(.N(NIRQ)) u_isr_enc (
        .vec   (isr),
        .valid (isr_valid),
        .id    (isr_id)
    );

    assign below_isr = isr_valid ? ((irq_vec_t'(1) << isr_id) - irq_vec_t'(1)) : '1;
    assign eligible  = pend & mask & below_isr;

    irq_prio_enc #(.N(NIRQ)) u_cand_enc (
        .vec   (eligible),
        .valid (cand_valid),
        .id    (cand_id)
    );

    assign ack_vec = ack ? (irq_vec_t'(1) << cand_id) : '0;
    assign eoi_vec = eoi ? (irq_vec_t'(1) << isr_id) : '0;
    assign w1c     = (wr_stb && addr == IRQ_PEND) ? din[NIRQ-1:0] : '0;

    // Edge bits: a new rising edge beats any clear. Level bits simply track the line.
    assign pend_next = (mode & ((irq_src & ~prev_src) | (pend & ~(w1c | ack_vec))))
                     | (~mode & irq_src);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            mask     <= RST_MASK;
            mode     <= '0;
            pend     <= '0;
            isr      <= '0;
            prev_src <= '0;
            hwint    <= '0;
            irq_any  <= 1'b0;
        end else begin
            prev_src <= irq_src;
            pend     <= pend_next;
            isr      <= (isr | ack_vec) & ~eoi_vec;
            hwint    <= eligible;
            irq_any  <= |eligible;
            if (wr_stb && addr == IRQ_MASK) mask <= din[NIRQ-1:0];
            if (wr_stb && addr == IRQ_MODE) mode <= din[NIRQ-1:0];
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            IRQ_MASK: dout[NIRQ-1:0] = mask;
            IRQ_MODE: dout[NIRQ-1:0] = mode;
            IRQ_PEND: dout[NIRQ-1:0] = pend;
            IRQ_STAT: dout = pack_status(cand_valid, isr, cand_id);
            default:  dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed, table-driven bench for irq_ctrl: one table row per clock cycle,
// plus a hand-written reset-during-service sequence.
module tb_irq_ctrl;

    localparam logic [5:0] TB_RST_MASK = 6'h05;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_src;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] din;
    logic [31:0] dout;
    logic [5:0]  hwint;
    logic        irq_any;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl #(.RST_MASK(TB_RST_MASK)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .re      (re),
        .din     (din),
        .dout    (dout),
        .hwint   (hwint),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  src;
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic [5:0]  exp_hwint;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] s, input logic w, input logic r,
                                input logic [1:0] a, input logic [31:0] d,
                                input logic [31:0] ed, input logic [5:0] eh);
        vec_t v;
        v.src = s; v.we = w; v.re = r; v.addr = a; v.din = d;
        v.exp_dout = ed; v.exp_hwint = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Expected values are for the cycle's inputs before the next rising edge;
        // hwint reflects state one edge behind PEND/MASK/ISR.
        // Level source 1 reaches hwint two cycles after assertion
        tbl.push_back(mk(6'h00, 1, 0, 2'd0, 32'h3F, 32'h0000_0005, 6'h00));
        tbl.push_back(mk(6'h02, 0, 0, 2'd0, 32'h00, 32'h0000_003F, 6'h00));
        tbl.push_back(mk(6'h02, 0, 0, 2'd3, 32'h00, 32'h8000_0001, 6'h00));
        tbl.push_back(mk(6'h02, 0, 0, 2'd2, 32'h00, 32'h0000_0002, 6'h02));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h8000_0001, 6'h02));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h02));
        // Edge source 0: pulse, persist, ack, EOI
        tbl.push_back(mk(6'h00, 1, 0, 2'd1, 32'h01, 32'h0000_0000, 6'h00));
        tbl.push_back(mk(6'h01, 0, 0, 2'd2, 32'h00, 32'h0000_0000, 6'h00));
        tbl.push_back(mk(6'h00, 0, 0, 2'd2, 32'h00, 32'h0000_0001, 6'h00));
        tbl.push_back(mk(6'h00, 0, 0, 2'd2, 32'h00, 32'h0000_0001, 6'h01));
        tbl.push_back(mk(6'h00, 0, 1, 2'd3, 32'h00, 32'h8000_0000, 6'h01));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0107, 6'h01));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0107, 6'h00));
        tbl.push_back(mk(6'h00, 1, 0, 2'd3, 32'h00, 32'h0000_0107, 6'h00));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h00));
        // Nesting: source 3 in service, source 1 preempts, two EOIs unwind
        tbl.push_back(mk(6'h08, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h00));
        tbl.push_back(mk(6'h08, 0, 1, 2'd3, 32'h00, 32'h8000_0003, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 0, 2'd3, 32'h00, 32'h0000_0807, 6'h08));
        tbl.push_back(mk(6'h0A, 0, 0, 2'd3, 32'h00, 32'h8000_0801, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 1, 2'd3, 32'h00, 32'h8000_0801, 6'h02));
        tbl.push_back(mk(6'h0A, 0, 0, 2'd3, 32'h00, 32'h0000_0A07, 6'h02));
        tbl.push_back(mk(6'h0A, 1, 0, 2'd3, 32'h00, 32'h0000_0A07, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 0, 2'd3, 32'h00, 32'h8000_0801, 6'h00));
        tbl.push_back(mk(6'h00, 1, 0, 2'd3, 32'h00, 32'h8000_0801, 6'h02));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h02));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h00));
        // Source 4 blocked while source 1 is in service
        tbl.push_back(mk(6'h02, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h00));
        tbl.push_back(mk(6'h02, 0, 1, 2'd3, 32'h00, 32'h8000_0001, 6'h00));
        tbl.push_back(mk(6'h12, 0, 0, 2'd3, 32'h00, 32'h0000_0207, 6'h02));
        tbl.push_back(mk(6'h12, 0, 0, 2'd3, 32'h00, 32'h0000_0207, 6'h00));
        tbl.push_back(mk(6'h10, 1, 0, 2'd3, 32'h00, 32'h0000_0207, 6'h00));
        tbl.push_back(mk(6'h10, 0, 0, 2'd3, 32'h00, 32'h8000_0004, 6'h00));
        tbl.push_back(mk(6'h10, 0, 0, 2'd3, 32'h00, 32'h8000_0004, 6'h10));
        // MASK=0 gates hwint but keeps PEND; restoring MASK brings it back
        tbl.push_back(mk(6'h10, 1, 0, 2'd0, 32'h00, 32'h0000_003F, 6'h10));
        tbl.push_back(mk(6'h10, 0, 0, 2'd2, 32'h00, 32'h0000_0010, 6'h10));
        tbl.push_back(mk(6'h10, 0, 0, 2'd2, 32'h00, 32'h0000_0010, 6'h00));
        tbl.push_back(mk(6'h10, 1, 0, 2'd0, 32'h3F, 32'h0000_0000, 6'h00));
        tbl.push_back(mk(6'h10, 0, 0, 2'd3, 32'h00, 32'h8000_0004, 6'h00));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h8000_0004, 6'h10));
        tbl.push_back(mk(6'h00, 0, 0, 2'd3, 32'h00, 32'h0000_0007, 6'h10));
        tbl.push_back(mk(6'h00, 0, 0, 2'd2, 32'h00, 32'h0000_0000, 6'h00));
        // W1C racing a new edge (set wins), plain W1C, W1C on a level bit
        tbl.push_back(mk(6'h01, 0, 0, 2'd2, 32'h00, 32'h0000_0000, 6'h00));
        tbl.push_back(mk(6'h00, 0, 0, 2'd2, 32'h00, 32'h0000_0001, 6'h00));
        tbl.push_back(mk(6'h01, 1, 0, 2'd2, 32'h01, 32'h0000_0001, 6'h01));
        tbl.push_back(mk(6'h00, 0, 0, 2'd2, 32'h00, 32'h0000_0001, 6'h01));
        tbl.push_back(mk(6'h00, 1, 0, 2'd2, 32'h01, 32'h0000_0001, 6'h01));
        tbl.push_back(mk(6'h00, 0, 0, 2'd2, 32'h00, 32'h0000_0000, 6'h01));
        tbl.push_back(mk(6'h04, 0, 0, 2'd2, 32'h00, 32'h0000_0000, 6'h00));
        tbl.push_back(mk(6'h04, 1, 0, 2'd2, 32'h3F, 32'h0000_0004, 6'h00));
        tbl.push_back(mk(6'h04, 0, 0, 2'd2, 32'h00, 32'h0000_0004, 6'h04));
        tbl.push_back(mk(6'h04, 0, 1, 2'd3, 32'h00, 32'h8000_0002, 6'h04));

        rst = 1'b1; irq_src = '0; sel = 1'b0; addr = '0; we = 1'b0; re = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (i != 0) @(negedge clk);
            irq_src = tbl[i].src;
            we      = tbl[i].we;
            re      = tbl[i].re;
            sel     = tbl[i].we | tbl[i].re;
            addr    = tbl[i].addr;
            din     = tbl[i].din;
            #1;
            check($sformatf("row%0d dout", i),    dout,           tbl[i].exp_dout);
            check($sformatf("row%0d hwint", i),   32'(hwint),     32'(tbl[i].exp_hwint));
            check($sformatf("row%0d irq_any", i), 32'(irq_any),   32'(|tbl[i].exp_hwint));
        end

        // Reset while source 2 is in service; its level line stays high throughout
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; din = '0; irq_src = 6'h04;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst hwint", 32'(hwint), 32'h0);
        check("rst irq_any", 32'(irq_any), 32'h0);
        addr = 2'd0; #1; check("rst mask", dout, 32'(TB_RST_MASK));
        addr = 2'd1; #1; check("rst mode", dout, 32'h0);
        addr = 2'd2; #1; check("rst pend", dout, 32'h0);
        addr = 2'd3; #1; check("rst status", dout, 32'h0000_0007);
        @(negedge clk);
        #1;
        check("post-rst status", dout, 32'h8000_0002);
        check("post-rst hwint0", 32'(hwint), 32'h0);
        @(negedge clk);
        #1;
        check("post-rst hwint", 32'(hwint), 32'h04);
        check("post-rst irq_any", 32'(irq_any), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller between the system bridge's peripherals and the CPU's CP0 HWInt[7:2] inputs.
- Arbitrates up to six device interrupt requests (timer on source 0, switch IRQ on source 1, the rest spare) with fixed priority, per-source masking, edge/level mode and in-service tracking.
- Produces the masked, priority-gated HWInt vector.
- The CPU configures and acknowledges it through a 4-word register window decoded by the bridge.

Parameters:
- NIRQ, 6: number of interrupt sources; fixed at 6 to match HWInt[7:2].
- RST_MASK, 6'h00: MASK register value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- irq_src  in  NIRQ  device request lines, synchronous to clk; bit 0 is the highest priority.
- sel  in  1  register window selected by the bridge.
- addr  in  2  word offset, from PrAddr[3:2].
- we  in  1  write strobe, one-cycle pulse, qualified by sel.
- re  in  1  read strobe, one-cycle pulse, qualified by sel; used only for read side effects.
- din  in  32  write data.
- dout  out  32  read data, combinational from addr.
- hwint  out  NIRQ  to CP0 HWInt[7:2], registered.
- irq_any  out  1  OR of hwint, registered.

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - MASK=RST_MASK; MODE, PEND, ISR and prev_src = 0.
  - hwint=0, irq_any=0.
  - Reset asserted mid-service drops all in-service state; no interrupt is lost silently only if its source is level mode and still asserted.
- Register map (word offsets):
  - 0 MASK: RW, [5:0]; 1 enables the source.
  - 1 MODE: RW, [5:0]; 1 = rising-edge, 0 = level.
  - 2 PEND: R, [5:0] raw pending. Write-1-to-clear applies to edge bits only; writes to level bits are ignored.
  - 3 STATUS: R.
    - [31] = valid candidate exists.
    - [13:8] = ISR.
    - [2:0] = id of the candidate, 3'h7 if none.
    - Any write = EOI.
  - Unused bits read 0. Partial-word writes are not supported; BE is decoded by the bridge.
- Pending:
  - Edge source i: PEND[i] sets when irq_src[i] & ~prev_src[i].
  - Level source i: PEND[i] = irq_src[i] registered each cycle.
  - Edge set and W1C clear in the same cycle: set wins.
  - Changing MODE from edge to level clears nothing; the level value overwrites PEND on the next cycle.
- Candidate: lowest index i with PEND[i] & MASK[i], where i < lowest set ISR bit (or ISR==0).
- hwint (registered, latency 1 cycle from PEND/MASK/ISR change):
  - hwint[i] = PEND[i] & MASK[i] & (i < lowest ISR bit).
  - irq_any = |hwint.
- Acknowledge:
  - On sel & re & addr==3 with a valid candidate k, at the clock edge: ISR[k] sets, and PEND[k] clears if source k is edge mode.
  - dout during that cycle shows the pre-ack candidate k.
  - No candidate: no state change.
- EOI: sel & we & addr==3 clears the lowest set ISR bit (the highest-priority in-service source); ISR==0 means no effect. din is ignored.
- Nesting: a higher-priority source may be acked while a lower one is in service; ISR then holds both bits, and EOIs unwind in priority order.
- Simultaneous ack and EOI cannot occur, since re and we are exclusive; if both are asserted, we wins and re is ignored.
- Masking a source does not clear its PEND or ISR bit.

Decomposition:
- Shared package: NIRQ, register offset constants (IRQ_MASK=0, IRQ_MODE=1, IRQ_PEND=2, IRQ_STAT=3), and the STATUS field bit positions, all shared with the bridge and the software header.
- One sub-module, irq_prio_enc: a NIRQ-wide lowest-index priority encoder returning valid and a 3-bit id. It is instantiated twice, once for the candidate and once for the lowest ISR bit.

Test Plan:
- Reset then MASK=6'h3F, MODE=0, irq_src=6'b000010 held -> after 2 cycles hwint=6'b000010 and irq_any=1; STATUS reads 32'h8000_0001.
- Edge source 0 (MODE=6'h01), 1-cycle pulse on irq_src[0] -> PEND=6'h01 persists after the pulse. A STATUS read acks it: PEND[0]=0, ISR=6'h01, hwint=0 next cycle. EOI -> ISR=0.
- Nesting: ack source 3 (ISR=6'h08), then assert level source 1 -> hwint=6'b000010, ack gives ISR=6'h0A. First EOI -> ISR=6'h08; second EOI -> ISR=0.
- Lower priority blocked: ISR=6'h02, source 4 pending and unmasked -> hwint=0, STATUS[31]=0, id=7. After EOI -> hwint=6'h10.
- W1C on an edge bit in the same cycle as a new rising edge on that source -> PEND bit remains 1. W1C on a level bit -> no change.
- MASK=0 with sources pending -> hwint=0 and PEND unchanged. Restoring MASK -> hwint reasserts 1 cycle later. rst mid-service -> all registers and outputs 0, MASK=RST_MASK.
